// File: rtl/icb_ra_poll_master.sv
// ICB initiator for the robotic-arm register block: periodic sweep of the stepper
// read window into a coherent snapshot, plus single-word register writes from local logic.
module icb_ra_poll_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1004_0030,
  parameter int          NWORDS    = 12,
  parameter int          PERIOD    = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   wr_req,
  input  logic [31:0]            wr_addr,
  input  logic [31:0]            wr_data,
  output logic                   wr_pend,
  output logic                   wr_done,
  output logic [32*NWORDS-1:0]   snap_data,
  output logic                   snap_valid,
  output logic                   busy,
  output logic                   poll_overrun,
  output logic                   o_icb_cmd_valid,
  input  logic                   o_icb_cmd_ready,
  output logic [31:0]            o_icb_cmd_addr,
  output logic                   o_icb_cmd_read,
  output logic [31:0]            o_icb_cmd_wdata,
  input  logic                   o_icb_rsp_valid,
  output logic                   o_icb_rsp_ready,
  input  logic [31:0]            o_icb_rsp_rdata
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic                  read_q, read_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  sweep_q, sweep_d;
  logic [TW-1:0]         timer_q;
  logic                  poll_pend_q, overrun_q;
  logic                  wr_pend_q;
  logic [31:0]           wr_addr_q, wr_data_q;
  logic                  wr_done_q, snap_valid_q;
  logic [31:0]           shadow_q [NWORDS];
  logic [32*NWORDS-1:0]  snap_q;

  logic done, launch, wr_clr, take_poll;

  function automatic logic [31:0] rd_addr(input logic [IW-1:0] i);
    return BASE_ADDR + (32'(i) << 2);
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    read_d    = read_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    sweep_d   = sweep_q;
    done      = 1'b0;
    launch    = 1'b0;
    wr_clr    = 1'b0;
    take_poll = 1'b0;
    unique case (state_q)
      IDLE: launch = 1'b1;
      CMD: begin
        // A responder may answer in the same cycle it accepts the command.
        if (o_icb_cmd_ready) begin
          if (o_icb_rsp_valid) done = 1'b1;
          else                 state_d = RSP;
        end
      end
      RSP:     done = o_icb_rsp_valid;
      default: state_d = IDLE;
    endcase
    if (done) begin
      launch = 1'b1;
      if (read_q) begin
        if (idx_q == LAST_IDX) sweep_d = 1'b0;
        else                   idx_d   = idx_q + 1'b1;
      end else begin
        wr_clr = 1'b1;
      end
    end
    // Next operation is picked in the completing cycle: writes slot in between sweep words.
    if (launch) begin
      if (wr_pend_q && !wr_clr) begin
        state_d = CMD;
        addr_d  = wr_addr_q;
        read_d  = 1'b0;
        wdata_d = wr_data_q;
      end else if (sweep_d) begin
        state_d = CMD;
        addr_d  = rd_addr(idx_d);
        read_d  = 1'b1;
        wdata_d = 32'd0;
      end else if (poll_pend_q) begin
        take_poll = 1'b1;
        sweep_d   = 1'b1;
        idx_d     = '0;
        state_d   = CMD;
        addr_d    = BASE_ADDR;
        read_d    = 1'b1;
        wdata_d   = 32'd0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      read_q       <= 1'b0;
      wdata_q      <= 32'd0;
      idx_q        <= '0;
      sweep_q      <= 1'b0;
      timer_q      <= '0;
      poll_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
      wr_done_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_q       <= '0;
      for (int k = 0; k < NWORDS; k++) shadow_q[k] <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      sweep_q      <= sweep_d;
      wr_done_q    <= done && !read_q;
      snap_valid_q <= done && read_q && (idx_q == LAST_IDX);
      if (!enable) begin
        timer_q     <= '0;
        poll_pend_q <= 1'b0;
        overrun_q   <= 1'b0;
      end else if (timer_q == LAST_TICK) begin
        timer_q     <= '0;
        poll_pend_q <= 1'b1;
        if (poll_pend_q && !take_poll) overrun_q <= 1'b1;
      end else begin
        timer_q <= timer_q + 1'b1;
        if (take_poll) poll_pend_q <= 1'b0;
      end
      if (wr_clr) begin
        wr_pend_q <= 1'b0;
      end else if (wr_req && !wr_pend_q) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      if (done && read_q) begin
        shadow_q[idx_q] <= o_icb_rsp_rdata;
        if (idx_q == LAST_IDX) begin
          for (int k = 0; k < NWORDS; k++)
            snap_q[32*k +: 32] <= (k == NWORDS - 1) ? o_icb_rsp_rdata : shadow_q[k];
        end
      end
    end
  end

  assign o_icb_cmd_valid = (state_q == CMD);
  assign o_icb_cmd_addr  = addr_q;
  assign o_icb_cmd_read  = read_q;
  assign o_icb_cmd_wdata = wdata_q;
  assign o_icb_rsp_ready = ((state_q == CMD) && o_icb_cmd_ready) || (state_q == RSP);
  assign busy            = (state_q != IDLE);
  assign wr_pend         = wr_pend_q;
  assign wr_done         = wr_done_q;
  assign snap_valid      = snap_valid_q;
  assign snap_data       = snap_q;
  assign poll_overrun    = overrun_q;

endmodule
